// File: rtl/cache_fill_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm_pkg
// Purpose  : Shared types and constants for the cache block fill engine:
//            FSM state encoding, default block geometry and the helper that
//            derives the byte-offset mask of one cache block.
// Revision : 1.0 - initial release
// ============================================================================
package cache_fill_fsm_pkg;

    // Default geometry: 16-bit byte addresses, 8 x 16-bit words per block.
    localparam int DEF_ADDR_WIDTH      = 16;
    localparam int DEF_WORDS_PER_BLOCK = 8;
    localparam int DEF_OFFSET_W        = $clog2(DEF_WORDS_PER_BLOCK);

    // Byte-offset bits inside one block (two bytes per word).
    function automatic int block_offset_mask(input int words_per_block);
        return (2 * words_per_block) - 1;
    endfunction

    localparam int DEF_BLOCK_OFFSET_MASK = block_offset_mask(DEF_WORDS_PER_BLOCK);

    // Explicitly encoded, explicitly sized fill FSM state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

endpackage : cache_fill_fsm_pkg
`default_nettype wire

// File: rtl/cache_fill_fsm_counter.sv
`default_nettype none
// ============================================================================
// Module   : fill_counter
// Purpose  : Saturating up-counter with synchronous clear and count enable.
//            Counts 0..MAX_VAL and then holds at MAX_VAL; clear wins over
//            enable.
// Ports    : clk   - clock, rising edge
//            rst   - asynchronous active-high reset (count -> 0)
//            clr   - synchronous clear to 0
//            en    - increment enable (ignored at saturation)
//            count - current count value
// Revision : 1.0 - initial release
// ============================================================================
module fill_counter #(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != c_MAX)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule : fill_counter
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : cache_fill_fsm
// Purpose  : Read-only memory initiator that fills one cache block on a miss.
//            Issues WORDS_PER_BLOCK word reads back-to-back, streams each
//            returned word into the data array and writes the tag together
//            with the last word. fsm_busy stalls the pipeline meanwhile.
// Ports    : clk, rst                      - clock / async active-high reset
//            miss_detected, miss_address   - miss request (sampled in IDLE)
//            fsm_busy                      - fill in progress (stall)
//            mem_addr, mem_en, mem_wr      - memory request side
//            mem_data_out, mem_data_valid  - memory response side
//            write_data_array, word_offset,
//            fill_data                     - data-array write port
//            write_tag_array               - tag/valid write strobe
// Revision : 1.0 - initial release
// ============================================================================
module cache_fill_fsm
    import cache_fill_fsm_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK   // power of 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               miss_detected,
    input  logic [ADDR_WIDTH-1:0]              miss_address,
    output logic                               fsm_busy,
    output logic [ADDR_WIDTH-1:0]              mem_addr,
    output logic                               mem_en,
    output logic                               mem_wr,
    input  logic [15:0]                        mem_data_out,
    input  logic                               mem_data_valid,
    output logic                               write_data_array,
    output logic                               write_tag_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] word_offset,
    output logic [15:0]                        fill_data
);

    localparam int c_OFFSET_W = $clog2(WORDS_PER_BLOCK);
    // One extra bit so a counter can represent "all WORDS_PER_BLOCK done".
    localparam int c_CNT_W    = c_OFFSET_W + 1;

    localparam logic [c_CNT_W-1:0]    c_WPB_CNT    = c_CNT_W'(WORDS_PER_BLOCK);
    localparam logic [c_CNT_W-1:0]    c_LAST_CNT   = c_CNT_W'(WORDS_PER_BLOCK - 1);
    localparam logic [ADDR_WIDTH-1:0] c_BLOCK_MASK =
        ~ADDR_WIDTH'(block_offset_mask(WORDS_PER_BLOCK));

    state_t                  r_state;
    state_t                  w_next_state;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [c_CNT_W-1:0]      w_issue_cnt;
    logic [c_CNT_W-1:0]      w_rcv_cnt;
    logic                    w_start;
    logic                    w_issuing;
    logic                    w_rcv_write;
    logic                    w_last_rcv;
    logic [c_OFFSET_W-1:0]   w_addr_idx;

    // ------------------------------------------------------------------
    // Control terms shared by the three FSM processes and the counters.
    // ------------------------------------------------------------------
    assign w_start     = (r_state == ST_IDLE) && miss_detected;
    assign w_issuing   = (r_state == ST_FILL) && (w_issue_cnt < c_WPB_CNT);
    // The rcv_cnt bound keeps an out-of-protocol extra strobe from writing.
    assign w_rcv_write = (r_state == ST_FILL) && mem_data_valid && (w_rcv_cnt < c_WPB_CNT);
    assign w_last_rcv  = w_rcv_write && (w_rcv_cnt == c_LAST_CNT);

    // ------------------------------------------------------------------
    // Request and response counters.
    // ------------------------------------------------------------------
    fill_counter #(
        .WIDTH   (c_CNT_W),
        .MAX_VAL (WORDS_PER_BLOCK)
    ) u_issue_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .en    (w_issuing),
        .count (w_issue_cnt)
    );

    fill_counter #(
        .WIDTH   (c_CNT_W),
        .MAX_VAL (WORDS_PER_BLOCK)
    ) u_rcv_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_start),
        .en    (w_rcv_write),
        .count (w_rcv_cnt)
    );

    // Block base is latched once per miss; misses during FILL are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base <= '0;
        end else if (w_start) begin
            r_base <= miss_address & c_BLOCK_MASK;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (miss_detected) w_next_state = ST_FILL;
            ST_FILL: if (w_last_rcv)    w_next_state = ST_IDLE;
            default:                    w_next_state = ST_IDLE;
        endcase
    end

    // Once the issue counter saturates, the address index sticks at the last
    // word so mem_addr holds its final value. From reset the counter is 0,
    // which together with the cleared base presents address 0.
    assign w_addr_idx = w_issue_cnt[c_CNT_W-1] ? {c_OFFSET_W{1'b1}}
                                               : w_issue_cnt[c_OFFSET_W-1:0];

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_busy         = 1'b0;
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = r_base | ADDR_WIDTH'({w_addr_idx, 1'b0});
        write_data_array = 1'b0;
        write_tag_array  = 1'b0;
        word_offset      = '0;
        fill_data        = '0;
        case (r_state)
            ST_IDLE: begin
                // Stall starts combinationally in the miss cycle itself.
                fsm_busy = miss_detected;
            end
            ST_FILL: begin
                fsm_busy         = 1'b1;
                mem_en           = w_issuing;
                write_data_array = w_rcv_write;
                write_tag_array  = w_last_rcv;
                if (w_rcv_write) begin
                    word_offset = w_rcv_cnt[c_OFFSET_W-1:0];
                    fill_data   = mem_data_out;
                end
            end
            default: begin
                fsm_busy = 1'b0;
            end
        endcase
    end

endmodule : cache_fill_fsm
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_fill_fsm
// Purpose  : Self-checking bench for cache_fill_fsm. A behavioural memory
//            with fixed per-fill latency returns words in request order;
//            expected addresses, writes and timing follow from the block
//            fill rules (base = address with block offset cleared, word k at
//            base + 2k, k-th response goes to offset k, tag with the last).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    localparam int AW  = 16;
    localparam int WPB = 8;
    localparam int OW  = 3;
    localparam int MAX_CYCLES = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic          fsm_busy;
    logic [AW-1:0] mem_addr;
    logic          mem_en;
    logic          mem_wr;
    logic [15:0]   mem_data_out;
    logic          mem_data_valid;
    logic          write_data_array;
    logic          write_tag_array;
    logic [OW-1:0] word_offset;
    logic [15:0]   fill_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .ADDR_WIDTH      (AW),
        .WORDS_PER_BLOCK (WPB)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .fsm_busy         (fsm_busy),
        .mem_addr         (mem_addr),
        .mem_en           (mem_en),
        .mem_wr           (mem_wr),
        .mem_data_out     (mem_data_out),
        .mem_data_valid   (mem_data_valid),
        .write_data_array (write_data_array),
        .write_tag_array  (write_tag_array),
        .word_offset      (word_offset),
        .fill_data        (fill_data)
    );

    // One complete (or reset-aborted) block fill starting with a miss in the
    // current IDLE cycle. abort_after > 0 pulses rst once that many words
    // have been written, then keeps delivering the outstanding responses.
    task automatic do_fill(input logic [AW-1:0] addr, input int lat,
                           input bit noise, input bit fixed_data,
                           input int abort_after);
        logic [AW-1:0] base;
        logic [15:0]   words [WPB];
        int            due_q[$];
        int            n_resp;
        int            idx;
        int            c_end;
        bit            exp_wr;
        bit            exp_en;
        bit            aborted;
        base    = addr & ~AW'(2 * WPB - 1);
        n_resp  = 0;
        c_end   = -1;
        aborted = 1'b0;
        for (int k = 0; k < WPB; k++)
            words[k] = fixed_data ? 16'(16'hA000 + k) : 16'($urandom);

        // Miss cycle (IDLE).
        miss_detected  = 1'b1;
        miss_address   = addr;
        mem_data_valid = 1'b0;
        mem_data_out   = 16'($urandom);
        @(negedge clk);
        n_tests++; if (fsm_busy !== 1'b1) begin n_fail++; $display("FAIL miss_busy addr=%h got=%b exp=1", addr, fsm_busy); end
        n_tests++; if (mem_en !== 1'b0 || write_data_array !== 1'b0) begin n_fail++; $display("FAIL miss_idle_quiet addr=%h mem_en=%b wr=%b exp=0/0", addr, mem_en, write_data_array); end
        @(posedge clk); #1;

        for (int c = 1; c <= MAX_CYCLES && c_end < 0 && !aborted; c++) begin
            miss_detected = noise ? 1'($urandom) : 1'b0;
            miss_address  = noise ? AW'($urandom) : addr;
            exp_wr = (due_q.size() > 0) && (due_q[0] == c);
            idx    = n_resp;
            if (exp_wr) begin
                assert (n_resp < WPB) else $error("protocol: response beyond block end");
                void'(due_q.pop_front());
                mem_data_valid = 1'b1;
                mem_data_out   = words[idx];
                n_resp++;
            end else begin
                mem_data_valid = 1'b0;
                mem_data_out   = noise ? 16'($urandom) : 16'h0000;
            end
            @(negedge clk);

            // Request side: one request per cycle for the first WPB cycles.
            exp_en = (c <= WPB);
            n_tests++; if (mem_en !== exp_en) begin n_fail++; $display("FAIL mem_en cyc=%0d got=%b exp=%b", c, mem_en, exp_en); end
            if (exp_en) begin
                due_q.push_back(c + lat);
                n_tests++; if (mem_addr !== AW'(base + 2 * (c - 1))) begin n_fail++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", c, mem_addr, AW'(base + 2 * (c - 1))); end
            end else begin
                n_tests++; if (mem_addr !== AW'(base + 2 * (WPB - 1))) begin n_fail++; $display("FAIL addr_hold cyc=%0d got=%h exp=%h", c, mem_addr, AW'(base + 2 * (WPB - 1))); end
            end
            n_tests++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL mem_wr cyc=%0d got=%b exp=0", c, mem_wr); end
            n_tests++; if (fsm_busy !== 1'b1) begin n_fail++; $display("FAIL fill_busy cyc=%0d got=%b exp=1", c, fsm_busy); end

            // Response side.
            n_tests++; if (write_data_array !== exp_wr) begin n_fail++; $display("FAIL data_wr cyc=%0d got=%b exp=%b", c, write_data_array, exp_wr); end
            n_tests++; if (write_tag_array !== (exp_wr && idx == WPB - 1)) begin n_fail++; $display("FAIL tag_wr cyc=%0d got=%b exp=%b", c, write_tag_array, exp_wr && idx == WPB - 1); end
            if (exp_wr) begin
                n_tests++; if (word_offset !== OW'(idx)) begin n_fail++; $display("FAIL word_offset cyc=%0d got=%0d exp=%0d", c, word_offset, idx); end
                n_tests++; if (fill_data !== words[idx]) begin n_fail++; $display("FAIL fill_data cyc=%0d got=%h exp=%h", c, fill_data, words[idx]); end
                if (idx == WPB - 1) c_end = c;
            end

            if (abort_after > 0 && exp_wr && n_resp == abort_after) begin
                aborted = 1'b1;
                @(posedge clk); #1;
                miss_detected = 1'b0;
                miss_address  = addr;
                for (int d = 0; d < lat + 3; d++) begin
                    rst = (d == 0);
                    if (due_q.size() > 0 && due_q[0] == c + 1 + d) begin
                        void'(due_q.pop_front());
                        mem_data_valid = 1'b1;
                        mem_data_out   = 16'($urandom);
                    end else begin
                        mem_data_valid = 1'b0;
                    end
                    #1;
                    n_tests++; if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin n_fail++; $display("FAIL abort_no_write d=%0d wr=%b tag=%b exp=0/0", d, write_data_array, write_tag_array); end
                    n_tests++; if (fsm_busy !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL abort_idle d=%0d busy=%b mem_en=%b exp=0/0", d, fsm_busy, mem_en); end
                    if (d <= 1) begin
                        n_tests++; if (mem_addr !== '0 || word_offset !== '0 || fill_data !== '0) begin n_fail++; $display("FAIL abort_zero d=%0d addr=%h off=%0d data=%h exp=0", d, mem_addr, word_offset, fill_data); end
                    end
                    @(posedge clk); #1;
                end
                rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end

        if (!aborted) begin
            n_tests++;
            if (c_end < 0) begin n_fail++; $display("FAIL fill_timeout addr=%h got=none exp=%0d cycles", addr, WPB + lat); end
            else if (c_end != WPB + lat) begin n_fail++; $display("FAIL fill_length addr=%h got=%0d exp=%0d", addr, c_end, WPB + lat); end
        end
        miss_detected  = 1'b0;
        mem_data_valid = 1'b0;
        mem_data_out   = 16'h0000;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        miss_detected  = 1'b0;
        miss_address   = 16'h1234;
        mem_data_valid = 1'b1;
        mem_data_out   = 16'hBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if ({fsm_busy, mem_en, mem_wr, write_data_array, write_tag_array} !== 5'b0) begin n_fail++; $display("FAIL reset_ctrl got=%b exp=00000", {fsm_busy, mem_en, mem_wr, write_data_array, write_tag_array}); end
        n_tests++; if (mem_addr !== '0 || word_offset !== '0 || fill_data !== '0) begin n_fail++; $display("FAIL reset_data addr=%h off=%0d data=%h exp=0", mem_addr, word_offset, fill_data); end
        @(posedge clk); #1;
        rst            = 1'b0;
        mem_data_valid = 1'b0;
        @(negedge clk);
        n_tests++; if ({fsm_busy, mem_en, write_data_array, write_tag_array} !== 4'b0 || mem_addr !== '0 || fill_data !== '0) begin n_fail++; $display("FAIL post_reset got=%b addr=%h exp=0", {fsm_busy, mem_en, write_data_array, write_tag_array}, mem_addr); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_fill();
        do_fill(16'h1236, 4, 1'b0, 1'b1, 0);
    endtask

    task automatic test_high_address();
        do_fill(16'hFFFF, 3, 1'b0, 1'b0, 0);
    endtask

    task automatic test_idle_noise();
        for (int i = 0; i < 3; i++) begin
            miss_detected  = 1'b0;
            mem_data_valid = 1'b1;
            mem_data_out   = 16'hDEAD;
            @(negedge clk);
            n_tests++; if (write_data_array !== 1'b0 || write_tag_array !== 1'b0) begin n_fail++; $display("FAIL idle_valid_write i=%0d wr=%b tag=%b exp=0/0", i, write_data_array, write_tag_array); end
            n_tests++; if (fsm_busy !== 1'b0 || mem_en !== 1'b0) begin n_fail++; $display("FAIL idle_valid_busy i=%0d busy=%b mem_en=%b exp=0/0", i, fsm_busy, mem_en); end
            @(posedge clk); #1;
        end
        mem_data_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_fill(16'h1000, 2, 1'b0, 1'b0, 0);
        do_fill(16'h0040, 5, 1'b0, 1'b0, 0);
    endtask

    task automatic test_reset_mid_fill();
        do_fill(16'h2468, 4, 1'b0, 1'b0, 3);
        do_fill(16'h2468, 4, 1'b0, 1'b1, 0);
    endtask

    task automatic test_fill_noise();
        do_fill(16'h5A5A, 3, 1'b1, 1'b0, 0);
    endtask

    task automatic test_latency1();
        do_fill(16'h0800, 1, 1'b0, 1'b1, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            do_fill(16'($urandom), int'($urandom_range(1, 6)), 1'($urandom), 1'b0, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic_fill();
        test_high_address();
        test_idle_noise();
        test_back_to_back();
        test_reset_mid_fill();
        test_fill_noise();
        test_latency1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_cache_fill_fsm
`default_nettype wire
